sm3_apb_regif: RTL and testbench

//  APB3 responder exposing the SM3 hash core to the CPU bus; the slave end of the SM3 register map.

---
 rtl/sm3_apb_regif.sv | 159 +++++++++++++++
 tb/tb_sm3_apb_regif.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_apb_regif.sv
// APB3 register interface for the SM3 hash core: message/length/control registers, start pulse, digest capture.
// Optional build macro: SM3_APB_SLVERR_EN enables PSLVERROR responses.
module sm3_apb_regif #(
   parameter logic [11:0] BASE_ADDR = 12'h200
) (
   input  logic         io_mainClk,
   input  logic         resetCtrl_systemReset,
   input  logic [11:0]  io_apb_PADDR,
   input  logic         io_apb_PSEL,
   input  logic         io_apb_PENABLE,
   input  logic         io_apb_PWRITE,
   input  logic [31:0]  io_apb_PWDATA,
   output logic [31:0]  io_apb_PRDATA,
   output logic         io_apb_PREADY,
   output logic         io_apb_PSLVERROR,
   output logic         io_SM3_interrupt,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic [31:0]  core_len,
   output logic [1:0]   core_mode,
   input  logic         core_done,
   input  logic [255:0] core_hash
);

   localparam int unsigned DW    = 32;
   localparam int unsigned NDATA = 16;
   localparam int unsigned NHASH = 8;
   localparam int unsigned AW    = 12;

   typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;
   typedef enum logic [1:0] {H_IDLE, H_BUSY, H_DONE} hash_state_e;

   apb_state_e  apb_q, apb_d;
   hash_state_e hstate_q, hstate_d;

   logic [DW-1:0] data_q [NDATA];
   logic [DW-1:0] hash_q [NHASH];
   logic [DW-1:0] len_q;
   logic [DW-1:0] prdata_q;
   logic [DW-1:0] rdata_c;
   logic [1:0]    mode_q;
   logic [1:0]    core_mode_q;
   logic          pready_q;
   logic          start_q, start_d;
   logic          irq_q;

   logic [AW-1:0] off_c;
   logic          addr_ok_c;
   logic [4:0]    idx_c;
   logic          busy_c;
   logic          done_c;
   logic          wr_ok_c;
   logic          wr_status_c;

   // Word index 0 = STATUS, 1..16 = DATA, 17 = LEN, 18..25 = HASH
   assign off_c       = io_apb_PADDR - BASE_ADDR;
   assign addr_ok_c   = (off_c <= 12'h064) && (off_c[1:0] == 2'b00);
   assign idx_c       = off_c[6:2];
   assign busy_c      = (hstate_q == H_BUSY);
   assign done_c      = (hstate_q == H_DONE);
   assign wr_ok_c     = (apb_q == A_ACCESS) && io_apb_PSEL && io_apb_PENABLE && io_apb_PWRITE
                        && addr_ok_c && !busy_c;
   assign wr_status_c = wr_ok_c && (idx_c == 5'd0);

   always_comb begin
      rdata_c = '0;
      if (addr_ok_c) begin
         if (idx_c == 5'd0)       rdata_c = {27'd0, done_c, busy_c, mode_q, 1'b0};
         else if (idx_c <= 5'd16) rdata_c = data_q[4'(idx_c - 5'd1)];
         else if (idx_c == 5'd17) rdata_c = len_q;
         else                     rdata_c = hash_q[3'(idx_c - 5'd18)];
      end
   end

   always_comb begin
      apb_d = apb_q;
      case (apb_q)
         A_IDLE:   if (io_apb_PSEL && !io_apb_PENABLE) apb_d = A_SETUP;
         A_SETUP:  apb_d = A_ACCESS;
         A_ACCESS: apb_d = A_IDLE;
         default:  apb_d = A_IDLE;
      endcase
   end

   // A done capture and a STATUS write can never both act: writes are blocked while busy
   always_comb begin
      hstate_d = hstate_q;
      start_d  = 1'b0;
      case (hstate_q)
         H_IDLE: if (wr_status_c && io_apb_PWDATA[0]) begin
            start_d  = 1'b1;
            hstate_d = H_BUSY;
         end
         H_BUSY: if (core_done) hstate_d = H_DONE;
         H_DONE: if (wr_status_c) begin
            start_d  = io_apb_PWDATA[0];
            hstate_d = io_apb_PWDATA[0] ? H_BUSY : H_IDLE;
         end
         default: hstate_d = H_IDLE;
      endcase
   end

   always_ff @(posedge io_mainClk) begin
      if (resetCtrl_systemReset) begin
         apb_q       <= A_IDLE;
         hstate_q    <= H_IDLE;
         prdata_q    <= '0;
         pready_q    <= 1'b0;
         start_q     <= 1'b0;
         irq_q       <= 1'b0;
         mode_q      <= '0;
         core_mode_q <= '0;
         len_q       <= '0;
         for (int i = 0; i < NDATA; i++) data_q[i] <= '0;
         for (int i = 0; i < NHASH; i++) hash_q[i] <= '0;
      end else begin
         apb_q    <= apb_d;
         hstate_q <= hstate_d;
         pready_q <= (apb_d == A_ACCESS);
         start_q  <= start_d;
         irq_q    <= (hstate_d == H_DONE);
         if (apb_q == A_SETUP && !io_apb_PWRITE) prdata_q <= rdata_c;
         if (wr_status_c) mode_q <= io_apb_PWDATA[2:1];
         if (start_d) core_mode_q <= io_apb_PWDATA[2:1];
         if (wr_ok_c && idx_c >= 5'd1 && idx_c <= 5'd16) data_q[4'(idx_c - 5'd1)] <= io_apb_PWDATA;
         if (wr_ok_c && idx_c == 5'd17) len_q <= io_apb_PWDATA;
         if (busy_c && core_done)
            for (int i = 0; i < NHASH; i++) hash_q[i] <= core_hash[DW*i +: DW];
      end
   end

`ifdef SM3_APB_SLVERR_EN
   logic err_c;
   logic slverr_q;
   assign err_c = !addr_ok_c || (io_apb_PWRITE && (idx_c >= 5'd18 || busy_c));

   always_ff @(posedge io_mainClk) begin
      if (resetCtrl_systemReset) slverr_q <= 1'b0;
      else                       slverr_q <= (apb_q == A_SETUP) && err_c;
   end
   assign io_apb_PSLVERROR = slverr_q;
`else
   assign io_apb_PSLVERROR = 1'b0;
`endif

   // DATA0 occupies the most significant word of the block
   always_comb begin
      core_block = '0;
      for (int i = 0; i < NDATA; i++) core_block[DW*(NDATA-1-i) +: DW] = data_q[i];
   end

   assign io_apb_PRDATA    = prdata_q;
   assign io_apb_PREADY    = pready_q;
   assign io_SM3_interrupt = irq_q;
   assign core_start       = start_q;
   assign core_len         = len_q;
   assign core_mode        = core_mode_q;

endmodule

// File: tb/tb_sm3_apb_regif.sv
// Self-checking bench for sm3_apb_regif: APB master task, vector table and a behavioural SM3 core stub.
module tb_sm3_apb_regif;

`ifdef SM3_APB_SLVERR_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif
   localparam logic [255:0] HASH =
      256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [11:0]  paddr = '0;
   logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]  pwdata = '0;
   logic [31:0]  prdata;
   logic         pready, slverr, irq, core_start;
   logic [511:0] core_block;
   logic [31:0]  core_len;
   logic [1:0]   core_mode;
   logic         core_done = 1'b0;
   logic [255:0] core_hash = HASH;

   int n_chk = 0, n_fail = 0;
   int ready_cnt = 0, start_cnt = 0, stub_cnt = 0;

   sm3_apb_regif dut (
      .io_mainClk(clk), .resetCtrl_systemReset(rst),
      .io_apb_PADDR(paddr), .io_apb_PSEL(psel), .io_apb_PENABLE(penable),
      .io_apb_PWRITE(pwrite), .io_apb_PWDATA(pwdata), .io_apb_PRDATA(prdata),
      .io_apb_PREADY(pready), .io_apb_PSLVERROR(slverr), .io_SM3_interrupt(irq),
      .core_start(core_start), .core_block(core_block), .core_len(core_len),
      .core_mode(core_mode), .core_done(core_done), .core_hash(core_hash)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pready) ready_cnt++;
      if (core_start) start_cnt++;
   end

   // Core stub: done pulse 64 cycles after start; not reset, so a late done can follow a reset
   always @(posedge clk) begin
      #2;
      core_done = 1'b0;
      if (core_start) stub_cnt = 64;
      else if (stub_cnt != 0) begin
         stub_cnt--;
         if (stub_cnt == 0) core_done = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
      logic got = 1'b0;
      rd = '0; er = 1'b0;
      @(posedge clk); #1;
      paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         if (pready) begin rd = prdata; er = slverr; got = 1'b1; end
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      if (!got) begin
         n_chk++; n_fail++;
         $display("FAIL apb_timeout: addr %h no PREADY", a);
      end
   endtask

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs [17];
   logic [31:0] rd;
   logic er;
   logic seen;

   initial begin
      vecs = '{
         '{12'h204, 1'b1, 32'h61626380, 32'h0, 1'b0},
         '{12'h240, 1'b1, 32'h00000018, 32'h0, 1'b0},
         '{12'h244, 1'b1, 32'h00000010, 32'h0, 1'b0},
         '{12'h206, 1'b1, 32'hFFFFFFFF, 32'h0, EN},
         '{12'h248, 1'b1, 32'h12345678, 32'h0, EN},
         '{12'h268, 1'b1, 32'h0BADF00D, 32'h0, EN},
         '{12'h1FC, 1'b1, 32'h0BADF00D, 32'h0, EN},
         '{12'h208, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0},
         '{12'h204, 1'b0, 32'h0, 32'h61626380, 1'b0},
         '{12'h208, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0},
         '{12'h240, 1'b0, 32'h0, 32'h00000018, 1'b0},
         '{12'h244, 1'b0, 32'h0, 32'h00000010, 1'b0},
         '{12'h248, 1'b0, 32'h0, 32'h00000000, 1'b0},
         '{12'h268, 1'b0, 32'h0, 32'h00000000, EN},
         '{12'h202, 1'b0, 32'h0, 32'h00000000, EN},
         '{12'h1FC, 1'b0, 32'h0, 32'h00000000, EN},
         '{12'h200, 1'b0, 32'h0, 32'h00000000, 1'b0}
      };

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_slverr", 32'(slverr), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_start", 32'(core_start), 32'h0);

      // All 26 registers read zero after reset
      for (int i = 0; i < 26; i++) begin
         apb(12'(32'h200 + 4*i), 1'b0, 32'h0, rd, er);
         chk($sformatf("rst_rd_%0d", i), rd, 32'h0);
      end
      chk("ready_pulses", 32'(ready_cnt), 32'd26);

      for (int i = 0; i < 17; i++) begin
         apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, er);
         if (!vecs[i].wr) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
      end
      chk("block_w0", core_block[511:480], 32'h61626380);
      chk("block_w1", core_block[479:448], 32'hA5A5A5A5);
      chk("block_w15", core_block[31:0], 32'h00000018);
      chk("core_len", core_len, 32'd16);

      // Start hash
      apb(12'h200, 1'b1, 32'h1, rd, er);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("status_busy", rd, 32'h8);
      chk("start_once", 32'(start_cnt), 32'd1);
      chk("mode_at_start", 32'(core_mode), 32'h0);

      // Writes while busy are dropped
      apb(12'h204, 1'b1, 32'hDEADBEEF, rd, er);
      chk("busy_wr_data_err", 32'(er), 32'(EN));
      apb(12'h200, 1'b1, 32'h0, rd, er);
      chk("busy_wr_stat_err", 32'(er), 32'(EN));
      apb(12'h204, 1'b0, 32'h0, rd, er);
      chk("busy_data0", rd, 32'h61626380);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("busy_status", rd, 32'h8);

      // Done capture and interrupt latency
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (core_done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'h1);
      chk("irq_before", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_after", 32'(irq), 32'h1);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("status_done", rd, 32'h10);
      apb(12'h248, 1'b0, 32'h0, rd, er);
      chk("hash0", rd, 32'h8f4ba8e0);
      apb(12'h254, 1'b0, 32'h0, rd, er);
      chk("hash3", rd, 32'h4167c487);
      apb(12'h264, 1'b0, 32'h0, rd, er);
      chk("hash7", rd, 32'h66c7f0f4);

      // Acknowledge, then restart with mode 2
      apb(12'h200, 1'b1, 32'h0, rd, er);
      @(negedge clk);
      chk("irq_cleared", 32'(irq), 32'h0);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("status_idle", rd, 32'h0);
      apb(12'h200, 1'b1, 32'h5, rd, er);
      repeat (2) @(negedge clk);
      chk("start_twice", 32'(start_cnt), 32'd2);
      chk("mode_10", 32'(core_mode), 32'h2);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("status_busy_m2", rd, 32'hC);

      // Reset mid-hash; the stub's late done must be ignored
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (core_done) seen = 1'b1;
      end
      chk("late_done_seen", 32'(seen), 32'h1);
      repeat (2) @(negedge clk);
      chk("late_irq", 32'(irq), 32'h0);
      apb(12'h248, 1'b0, 32'h0, rd, er);
      chk("late_hash0", rd, 32'h0);
      apb(12'h264, 1'b0, 32'h0, rd, er);
      chk("late_hash7", rd, 32'h0);
      apb(12'h200, 1'b0, 32'h0, rd, er);
      chk("late_status", rd, 32'h0);
      apb(12'h268, 1'b0, 32'h0, rd, er);
      chk("rd_268", rd, 32'h0);
      chk("rd_268_err", 32'(er), 32'(EN));
      apb(12'h202, 1'b0, 32'h0, rd, er);
      chk("rd_202", rd, 32'h0);
      chk("rd_202_err", 32'(er), 32'(EN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
